// File: rtl/divisor_ctrl_fsm.sv
// divisor_ctrl_fsm
//   Sequencer between the keypad decoder and the integer divider datapath.
//   Builds decimal operands A and B from key codes, issues a single start
//   pulse to the divider, waits for its done, and presents the quotient and
//   remainder to the 7-segment driver. Handles clear, early enter,
//   divide-by-zero and divider timeout.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_key_valid  one-cycle pulse per debounced key press
//   i_key_code   0-9 digit, 0xA enter, 0xC clear, other codes ignored
//   o_div_start  one-cycle start pulse to the divider
//   o_div_a      dividend, stable from START until WAIT exits
//   o_div_b      divisor, stable from START until WAIT exits
//   i_div_done   divider completion pulse
//   i_div_q      quotient, valid with i_div_done
//   i_div_r      remainder, valid with i_div_done
//   o_disp_hi    left display value (binary)
//   o_disp_lo    right display value (binary)
//   o_disp_err   error indicator for the display
//   o_busy       high in START and WAIT
//   o_state      current state encoding
//
// State | Meaning
//   ENTER_A (0) | collecting digits of A
//   ENTER_B (1) | collecting digits of B
//   START   (2) | one cycle; start pulse out, or ERR when B is zero
//   WAIT    (3) | waiting for divider done, bounded by TIMEOUT cycles
//   SHOW    (4) | quotient/remainder on display
//   ERR     (5) | divide-by-zero or timeout; only clear leaves

module divisor_ctrl_fsm #(
  parameter int DIGITS  = 2,
  parameter int W       = 7,
  parameter int TIMEOUT = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_key_valid,
  input  logic [3:0]   i_key_code,
  output logic         o_div_start,
  output logic [W-1:0] o_div_a,
  output logic [W-1:0] o_div_b,
  input  logic         i_div_done,
  input  logic [W-1:0] i_div_q,
  input  logic [W-1:0] i_div_r,
  output logic [W-1:0] o_disp_hi,
  output logic [W-1:0] o_disp_lo,
  output logic         o_disp_err,
  output logic         o_busy,
  output logic [2:0]   o_state
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  // Timer is a down-counter loaded on entry to WAIT; reaching zero without a
  // done means TIMEOUT WAIT cycles have elapsed.
  localparam logic [TW-1:0] T_LOAD   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t        r_state,     w_state;
  logic [W-1:0]  r_a,         w_a;
  logic [W-1:0]  r_b,         w_b;
  logic [CW-1:0] r_cnt,       w_cnt;
  logic [TW-1:0] r_timer,     w_timer;
  logic          r_div_start, w_div_start;
  logic [W-1:0]  r_div_a,     w_div_a;
  logic [W-1:0]  r_div_b,     w_div_b;
  logic [W-1:0]  r_disp_hi,   w_disp_hi;
  logic [W-1:0]  r_disp_lo,   w_disp_lo;
  logic          r_disp_err,  w_disp_err;

  logic          w_key_dig;
  logic          w_key_ent;
  logic          w_key_clr;
  logic          w_do_clear;
  logic [W-1:0]  w_acc_a;
  logic [W-1:0]  w_acc_b;
  logic [CW-1:0] w_cnt_inc;

  assign w_key_dig = i_key_valid && (i_key_code <= 4'd9);
  assign w_key_ent = i_key_valid && (i_key_code == 4'hA);
  assign w_key_clr = i_key_valid && (i_key_code == 4'hC);

  // Keys are dropped entirely in START and WAIT, clear included.
  assign w_do_clear = w_key_clr && ((r_state == S_ENTER_A) || (r_state == S_ENTER_B) ||
                                    (r_state == S_SHOW)    || (r_state == S_ERR));

  // Accumulation deliberately wraps in W bits.
  assign w_acc_a   = r_a * W'(10) + W'(i_key_code);
  assign w_acc_b   = r_b * W'(10) + W'(i_key_code);
  assign w_cnt_inc = r_cnt + CW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_ENTER_A;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_div_start <= 1'b0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_disp_hi   <= '0;
      r_disp_lo   <= '0;
      r_disp_err  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_a         <= w_a;
      r_b         <= w_b;
      r_cnt       <= w_cnt;
      r_timer     <= w_timer;
      r_div_start <= w_div_start;
      r_div_a     <= w_div_a;
      r_div_b     <= w_div_b;
      r_disp_hi   <= w_disp_hi;
      r_disp_lo   <= w_disp_lo;
      r_disp_err  <= w_disp_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_a         = r_a;
    w_b         = r_b;
    w_cnt       = r_cnt;
    w_timer     = r_timer;
    w_div_start = 1'b0;
    w_div_a     = r_div_a;
    w_div_b     = r_div_b;
    w_disp_hi   = r_disp_hi;
    w_disp_lo   = r_disp_lo;
    w_disp_err  = r_disp_err;

    case (r_state)
      S_ENTER_A: begin
        if (w_key_dig) begin
          w_a       = w_acc_a;
          w_disp_hi = w_acc_a;
          w_disp_lo = '0;
          if (w_cnt_inc == CNT_FULL) begin
            w_state = S_ENTER_B;
            w_cnt   = '0;
          end else begin
            w_cnt   = w_cnt_inc;
          end
        end else if (w_key_ent && (r_cnt != '0)) begin
          w_state = S_ENTER_B;
          w_cnt   = '0;
        end
      end

      S_ENTER_B: begin
        if (w_key_dig) begin
          w_b       = w_acc_b;
          w_disp_lo = w_acc_b;
          if (w_cnt_inc == CNT_FULL) begin
            w_state = S_START;
            w_cnt   = '0;
          end else begin
            w_cnt   = w_cnt_inc;
          end
        end else if (w_key_ent && (r_cnt != '0)) begin
          w_state = S_START;
          w_cnt   = '0;
        end
        // The start pulse is registered on the way into START so it is high
        // for exactly the START cycle; a zero divisor never launches.
        if ((w_state == S_START) && (w_b != '0)) begin
          w_div_start = 1'b1;
          w_div_a     = r_a;
          w_div_b     = w_b;
        end
      end

      S_START: begin
        if (r_b == '0) begin
          w_state    = S_ERR;
          w_disp_err = 1'b1;
          w_disp_hi  = '0;
          w_disp_lo  = '0;
        end else begin
          w_state    = S_WAIT;
          w_timer    = T_LOAD;
        end
      end

      S_WAIT: begin
        if (i_div_done) begin
          w_state   = S_SHOW;
          w_disp_hi = i_div_q;
          w_disp_lo = i_div_r;
        end else if (r_timer == '0) begin
          w_state    = S_ERR;
          w_disp_err = 1'b1;
          w_disp_hi  = '0;
          w_disp_lo  = '0;
        end else begin
          w_timer    = r_timer - TW'(1);
        end
      end

      S_SHOW: begin
        // A digit starts a fresh calculation with itself as first digit of A.
        if (w_key_dig) begin
          w_a       = W'(i_key_code);
          w_b       = '0;
          w_disp_hi = W'(i_key_code);
          w_disp_lo = '0;
          if (CNT_FULL == CW'(1)) begin
            w_state = S_ENTER_B;
            w_cnt   = '0;
          end else begin
            w_state = S_ENTER_A;
            w_cnt   = CW'(1);
          end
        end
      end

      S_ERR: begin
      end

      default: begin
        w_state = S_ENTER_A;
      end
    endcase

    if (w_do_clear) begin
      w_state    = S_ENTER_A;
      w_a        = '0;
      w_b        = '0;
      w_cnt      = '0;
      w_disp_hi  = '0;
      w_disp_lo  = '0;
      w_disp_err = 1'b0;
    end
  end

  assign o_div_start = r_div_start;
  assign o_div_a     = r_div_a;
  assign o_div_b     = r_div_b;
  assign o_disp_hi   = r_disp_hi;
  assign o_disp_lo   = r_disp_lo;
  assign o_disp_err  = r_disp_err;
  assign o_busy      = (r_state == S_START) || (r_state == S_WAIT);
  assign o_state     = r_state;

endmodule
